// File: rtl/mem_copy_engine_pkg.sv
// Shared encodings and defaults for the block-transfer engine.
package mem_copy_engine_pkg;

   localparam int DEFAULT_ADDR_WIDTH = 8;
   localparam int DEFAULT_LINE_WIDTH = 4;

   localparam logic MODE_COPY = 1'b0;
   localparam logic MODE_FILL = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Memory port bundle between the copy engine (master) and the memory array (slave).
interface mem_copy_engine_if
   import mem_copy_engine_pkg::*;
#(
   parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

   logic [ADDR_WIDTH-1:0] mem_read_address;
   logic [LINE_WIDTH-1:0] mem_read_data;
   logic [ADDR_WIDTH-1:0] mem_write_address;
   logic [LINE_WIDTH-1:0] mem_write_data;
   logic                  mem_write_enable;

   modport master (
      output mem_read_address,
      input  mem_read_data,
      output mem_write_address,
      output mem_write_data,
      output mem_write_enable
   );

   modport slave (
      input  mem_read_address,
      output mem_read_data,
      input  mem_write_address,
      input  mem_write_data,
      input  mem_write_enable
   );

endinterface

// File: rtl/mem_copy_engine.sv
// Block-transfer bus initiator: copies or fills a run of memory words, all outputs registered.
//
// state    | meaning
// ST_IDLE  | waiting for start; operands latched on acceptance
// ST_READ  | src pointer presented to memory, read data captured at the edge
// ST_WRITE | one word written at dst pointer; pointers advance, count drops
// ST_DONE  | single-cycle done pulse, then back to idle
module mem_copy_engine
   import mem_copy_engine_pkg::*;
#(
   parameter int LINE_WIDTH = DEFAULT_LINE_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  mode,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [ADDR_WIDTH-1:0] length,
   input  logic [LINE_WIDTH-1:0] fill_value,
   output logic                  busy,
   output logic                  done,
   mem_copy_engine_if.master     mem
);

   state_t                state;
   state_t                state_nxt;
   logic                  mode_q;
   logic                  mode_nxt;
   logic [ADDR_WIDTH-1:0] src_ptr;
   logic [ADDR_WIDTH-1:0] src_nxt;
   logic [ADDR_WIDTH-1:0] dst_ptr;
   logic [ADDR_WIDTH-1:0] dst_nxt;
   logic [ADDR_WIDTH-1:0] count;
   logic [ADDR_WIDTH-1:0] count_nxt;
   logic [LINE_WIDTH-1:0] data_q;
   logic [LINE_WIDTH-1:0] data_nxt;
   logic                  we_q;

   // In FILL the data register simply holds fill_value for the whole run.
   always_comb begin
      state_nxt = state;
      mode_nxt  = mode_q;
      src_nxt   = src_ptr;
      dst_nxt   = dst_ptr;
      count_nxt = count;
      data_nxt  = data_q;
      case (state)
         ST_IDLE: begin
            if (start) begin
               mode_nxt  = mode;
               src_nxt   = src_addr;
               dst_nxt   = dst_addr;
               count_nxt = length;
               data_nxt  = fill_value;
               if (length == '0) begin
                  state_nxt = ST_DONE;
               end else if (mode == MODE_FILL) begin
                  state_nxt = ST_WRITE;
               end else begin
                  state_nxt = ST_READ;
               end
            end
         end
         ST_READ: begin
            data_nxt  = mem.mem_read_data;
            state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            src_nxt   = src_ptr + ADDR_WIDTH'(1);
            dst_nxt   = dst_ptr + ADDR_WIDTH'(1);
            count_nxt = count - ADDR_WIDTH'(1);
            if (count == ADDR_WIDTH'(1)) begin
               state_nxt = ST_DONE;
            end else if (mode_q == MODE_FILL) begin
               state_nxt = ST_WRITE;
            end else begin
               state_nxt = ST_READ;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Status and write strobe are decoded from the next state so they are flop outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         mode_q  <= MODE_COPY;
         src_ptr <= '0;
         dst_ptr <= '0;
         count   <= '0;
         data_q  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state   <= state_nxt;
         mode_q  <= mode_nxt;
         src_ptr <= src_nxt;
         dst_ptr <= dst_nxt;
         count   <= count_nxt;
         data_q  <= data_nxt;
         busy    <= (state_nxt == ST_READ) || (state_nxt == ST_WRITE);
         done    <= (state_nxt == ST_DONE);
         we_q    <= (state_nxt == ST_WRITE);
      end
   end

   assign mem.mem_read_address  = src_ptr;
   assign mem.mem_write_address = dst_ptr;
   assign mem.mem_write_data    = data_q;
   assign mem.mem_write_enable  = we_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench: memory array model, transaction-level bus-cycle model, random and directed transfers.
module tb_mem_copy_engine;
   import mem_copy_engine_pkg::*;

   localparam int LW    = 4;
   localparam int AW    = 8;
   localparam int CELLS = 256;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       we;
      logic       rd;
      logic [7:0] ra;
      logic [7:0] wa;
      logic [3:0] wd;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          mode;
   logic [AW-1:0] src_addr;
   logic [AW-1:0] dst_addr;
   logic [AW-1:0] length;
   logic [LW-1:0] fill_value;
   logic          busy;
   logic          done;

   logic          pre_en;
   logic [AW-1:0] pre_addr;
   logic [LW-1:0] pre_data;
   logic [LW-1:0] mem     [CELLS];
   logic [LW-1:0] ref_mem [CELLS];

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   mem_copy_engine_if #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) bus ();

   mem_copy_engine #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .mode       (mode),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .length     (length),
      .fill_value (fill_value),
      .busy       (busy),
      .done       (done),
      .mem        (bus)
   );

   always #5 clk = ~clk;

   // Memory under the engine: combinational read, write at the clock edge.
   assign bus.mem_read_data = mem[bus.mem_read_address];

   always @(posedge clk) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      else if (bus.mem_write_enable) mem[bus.mem_write_address] <= bus.mem_write_data;
   end

   function automatic void chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endfunction

   function automatic void check_image(string name);
      int diffs = 0;
      for (int i = 0; i < CELLS; i++) if (mem[i] !== ref_mem[i]) diffs++;
      chk(name, diffs, 0);
   endfunction

   // Expected bus activity of one transfer, cycle by cycle, from a forward word-by-word copy.
   task automatic push_trace(logic m, logic [7:0] s, logic [7:0] d, logic [7:0] n, logic [3:0] fv);
      logic [3:0] img [CELLS];
      logic [7:0] sp;
      logic [7:0] dp;
      logic [3:0] v;
      exp_t       e;
      img = ref_mem;
      sp  = s;
      dp  = d;
      for (int i = 0; i < int'(n); i++) begin
         if (m == MODE_COPY) begin
            e = '0; e.busy = 1'b1; e.rd = 1'b1; e.ra = sp;
            exp_q.push_back(e);
            v = img[sp];
         end else begin
            v = fv;
         end
         img[dp] = v;
         e = '0; e.busy = 1'b1; e.we = 1'b1; e.wa = dp; e.wd = v;
         exp_q.push_back(e);
         sp = sp + 8'd1;
         dp = dp + 8'd1;
      end
      e = '0; e.done = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic compare_proc();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = '0;
            chk("busy", int'(busy), int'(e.busy));
            chk("done", int'(done), int'(e.done));
            chk("write_enable", int'(bus.mem_write_enable), int'(e.we));
            if (e.we) begin
               chk("write_address", int'(bus.mem_write_address), int'(e.wa));
               chk("write_data", int'(bus.mem_write_data), int'(e.wd));
               ref_mem[e.wa] = e.wd;
            end
            if (e.rd) chk("read_address", int'(bus.mem_read_address), int'(e.ra));
         end
      end
   endtask

   task automatic preload(logic [7:0] a, logic [3:0] d);
      @(posedge clk);
      #1;
      pre_en = 1'b1; pre_addr = a; pre_data = d;
      ref_mem[a] = d;
      @(posedge clk);
      #1;
      pre_en = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain", exp_q.size(), 0);
   endtask

   task automatic run_xfer(logic m, logic [7:0] s, logic [7:0] d, logic [7:0] n, logic [3:0] fv,
                           bit poke, output int done_cyc, output bit saw_we);
      int limit;
      int exp_dc;
      wait_drain();
      @(negedge clk);
      start = 1'b1; mode = m; src_addr = s; dst_addr = d; length = n; fill_value = fv;
      @(posedge clk);
      push_trace(m, s, d, n, fv);
      #1 start = 1'b0;
      done_cyc = -1;
      saw_we   = 1'b0;
      limit    = 2 * int'(n) + 8;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clk);
         if (bus.mem_write_enable) saw_we = 1'b1;
         if (done) begin
            done_cyc = k;
            break;
         end
         mode       = 1'($urandom);
         src_addr   = 8'($urandom);
         dst_addr   = 8'($urandom);
         length     = 8'($urandom);
         fill_value = 4'($urandom);
         start      = (poke && k == 3);
      end
      start = 1'b0;
      if (n == 8'd0) exp_dc = 1;
      else if (m == MODE_COPY) exp_dc = 2 * int'(n) + 1;
      else exp_dc = int'(n) + 1;
      chk("done_cycle", done_cyc, exp_dc);
      check_image("mem_image");
   endtask

   task automatic reset_mid_fill();
      wait_drain();
      @(negedge clk);
      start = 1'b1; mode = MODE_FILL; src_addr = 8'h00; dst_addr = 8'h60; length = 8'd8;
      fill_value = 4'hC;
      @(posedge clk);
      push_trace(MODE_FILL, 8'h00, 8'h60, 8'd8, 4'hC);
      #1 start = 1'b0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      exp_q.delete();
      #1;
      chk("rst_mid_we", int'(bus.mem_write_enable), 0);
      chk("rst_mid_busy", int'(busy), 0);
      chk("rst_mid_done", int'(done), 0);
      chk("rst_mid_waddr", int'(bus.mem_write_address), 0);
      @(negedge clk);
      @(negedge clk);
      #1 reset = 1'b0;
      repeat (4) begin
         @(negedge clk);
         #1 chk("no_done_after_rst", int'(done), 0);
      end
      chk("rst_cell_62", int'(mem[8'h62]), 12);
      chk("rst_cell_63", int'(mem[8'h63]), 1);
      check_image("rst_mem_image");
   endtask

   initial begin
      int         dc;
      bit         sw;
      logic       m;
      logic [7:0] s;
      logic [7:0] d;
      logic [7:0] n;
      logic [3:0] fv;

      reset = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
      fill_value = '0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
      fork
         compare_proc();
      join_none

      #2;
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_we", int'(bus.mem_write_enable), 0);
      chk("reset_raddr", int'(bus.mem_read_address), 0);
      chk("reset_waddr", int'(bus.mem_write_address), 0);
      chk("reset_wdata", int'(bus.mem_write_data), 0);

      for (int i = 0; i < CELLS; i++) preload(8'(i), 4'($urandom));
      @(negedge clk);
      reset = 1'b0;

      // FILL of four words, neighbour cell untouched.
      preload(8'h14, 4'h3);
      run_xfer(MODE_FILL, 8'h00, 8'h10, 8'd4, 4'hA, 1'b0, dc, sw);
      chk("fill_done_cyc", dc, 5);
      for (int i = 0; i < 4; i++) chk("fill_cell", int'(mem[16 + i]), 10);
      chk("fill_keep_14", int'(mem[8'h14]), 3);

      // COPY of three words.
      preload(8'h00, 4'h1);
      preload(8'h01, 4'h2);
      preload(8'h02, 4'h3);
      run_xfer(MODE_COPY, 8'h00, 8'h80, 8'd3, 4'h0, 1'b0, dc, sw);
      chk("copy_done_cyc", dc, 7);
      chk("copy_cell_80", int'(mem[8'h80]), 1);
      chk("copy_cell_81", int'(mem[8'h81]), 2);
      chk("copy_cell_82", int'(mem[8'h82]), 3);

      // start pulsed with scrambled operands in the middle of a COPY.
      run_xfer(MODE_COPY, 8'h20, 8'h30, 8'd5, 4'h0, 1'b1, dc, sw);
      chk("poke_done_cyc", dc, 11);

      // Destination wraps past the top of the address space.
      run_xfer(MODE_FILL, 8'h00, 8'hFE, 8'd3, 4'h5, 1'b0, dc, sw);
      chk("wrap_done_cyc", dc, 4);
      chk("wrap_cell_fe", int'(mem[8'hFE]), 5);
      chk("wrap_cell_ff", int'(mem[8'hFF]), 5);
      chk("wrap_cell_00", int'(mem[8'h00]), 5);

      // Zero length: immediate done, no write.
      run_xfer(MODE_COPY, 8'h05, 8'h06, 8'd0, 4'h0, 1'b0, dc, sw);
      chk("len0_done_cyc", dc, 1);
      chk("len0_no_we", int'(sw), 0);

      // Overlapping forward copy propagates the first source word.
      preload(8'h40, 4'h7);
      run_xfer(MODE_COPY, 8'h40, 8'h41, 8'd4, 4'h0, 1'b0, dc, sw);
      chk("overlap_cell_44", int'(mem[8'h44]), 7);

      preload(8'h63, 4'h1);
      reset_mid_fill();
      run_xfer(MODE_FILL, 8'h00, 8'h70, 8'd2, 4'h9, 1'b0, dc, sw);
      chk("post_rst_done_cyc", dc, 3);
      chk("post_rst_cell_71", int'(mem[8'h71]), 9);

      for (int t = 0; t < 25; t++) begin
         m  = 1'($urandom_range(0, 1));
         s  = 8'($urandom);
         d  = 8'($urandom);
         n  = 8'($urandom_range(0, 16));
         fv = 4'($urandom);
         run_xfer(m, s, d, n, fv, 1'b0, dc, sw);
         if (n == 8'd0) chk("rand_len0_no_we", int'(sw), 0);
      end

      wait_drain();
      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Bus initiator that drives the read and write ports of the `memory` array to perform block transfers. It sits beside the CPU datapath and is the master side of the memory's address/data/write_enable interface. Each transfer either copies `length` words from `src_addr` to `dst_addr` or fills `length` words at `dst_addr` with a constant. It reports progress with `busy` and a one-cycle `done` pulse.

## Interface
- `LINE_WIDTH`, default 4: data word width; must equal the attached memory's `LINE_WIDTH`.
- `ADDR_WIDTH`, default 8: address width; the address space has 2^ADDR_WIDTH cells.
- `clk  in  1`: single clock, rising edge.
- `reset  in  1`: reset is asynchronous and active-high.
- `start  in  1`: request a transfer; sampled only in IDLE.
- `mode  in  1`: 0 = COPY, 1 = FILL; latched on start.
- `src_addr  in  ADDR_WIDTH`: COPY source base; latched on start.
- `dst_addr  in  ADDR_WIDTH`: destination base; latched on start.
- `length  in  ADDR_WIDTH`: word count, 0..2^ADDR_WIDTH-1; latched on start.
- `fill_value  in  LINE_WIDTH`: FILL data; latched on start.
- `busy  out  1`: high from the cycle after start is accepted until the last write completes.
- `done  out  1`: one-cycle pulse after a transfer ends.
- `mem_read_address  out  ADDR_WIDTH`: to memory `read_address`.
- `mem_read_data  in  LINE_WIDTH`: from memory `read_data`. This path is combinational in the memory.
- `mem_write_address  out  ADDR_WIDTH`: to memory `write_address`.
- `mem_write_data  out  LINE_WIDTH`: to memory `write_data`.
- `mem_write_enable  out  1`: to memory `write_enable`.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE with `start`=1:
  - latch all inputs and set `count` = `length`.
  - `length`=0: go to DONE.
  - COPY: go to READ.
  - FILL: go to WRITE.
- READ (COPY only):
  - `mem_read_address` = src pointer.
  - At the clock edge, capture `mem_read_data` into the data register and go to WRITE.
- WRITE:
  - `mem_write_enable`=1, with address = dst pointer and data = data register (COPY) or `fill_value` (FILL).
  - At the clock edge, increment both pointers and decrement `count`.
  - If `count` becomes 0, go to DONE.
  - Otherwise go to READ (COPY) or stay in WRITE (FILL).
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Pointers increment modulo 2^ADDR_WIDTH: address 255 is followed by 0.
- COPY always proceeds forward, one word read then written. Overlap with dst > src therefore propagates already-written data; this is defined behaviour, not an error.
- `start` in any state other than IDLE is ignored. Input changes after acceptance have no effect.
- Reset values: state IDLE; `busy`, `done`, `mem_write_enable` = 0; all addresses and data = 0.
- Reset mid-transfer: `mem_write_enable` drops asynchronously and no `done` is issued. Memory contents written so far remain.

## Timing
- All outputs are registered. `mem_write_enable` must be glitch-free because the memory's write is level-sensitive.
- Address and data are stable for the entire cycle in which `mem_write_enable`=1.
- Start accepted at edge E0; `busy`=1 from E0.
- COPY of N>0 words:
  - READ/WRITE alternate over cycles 1..2N.
  - `done` is high in cycle 2N+1 and `busy`=0 from that cycle.
- FILL of N>0 words: WRITE occupies cycles 1..N; `done` is high in cycle N+1.
- `length`=0: `done` in cycle 1, no memory write.
- Back-to-back: `start` may be asserted in the `done` cycle, but it is accepted only once IDLE is re-entered, one cycle later.

## Structure
- Shared package holds:
  - state encoding: `ST_IDLE`, `ST_READ`, `ST_WRITE`, `ST_DONE`.
  - mode constants: `MODE_COPY`=0, `MODE_FILL`=1.
  - default `ADDR_WIDTH`.
- Single module; no sub-module required. The FSM, two address pointers, counter and data register are all local.

## Test plan
- FILL: dst=0x10, len=4, fill=0xA → cells 0x10..0x13 = 0xA, cell 0x14 unchanged; `done` 5 cycles after start.
- COPY: preload 0x00..0x02 = 1,2,3; src=0x00, dst=0x80, len=3 → 0x80..0x82 = 1,2,3; `done` at cycle 7.
- Wrap: FILL dst=0xFE, len=3, fill=0x5 → cells 0xFE, 0xFF, 0x00 = 0x5.
- `length`=0 → `done` in cycle 1, `mem_write_enable` never asserted.
- `start` pulsed mid-COPY with different operands → ignored; the original transfer completes unchanged.
- `reset` asserted in the middle of a FILL of length 8 → `mem_write_enable`=0 immediately, no `done`; the next start works normally.
